// File: rtl/main_memory.sv
// Fixed-latency 128-bit line memory behind a req/ready handshake.
// Requests are accepted in IDLE and answered with a one-cycle mem_ready pulse.
module main_memory #(
  parameter int LINE_IDX_W = 10,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_req,
  input  logic         mem_we,
  input  logic [31:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int DEPTH = 1 << LINE_IDX_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  state_t                next_state;
  logic [3:0]            lat_cnt;
  logic                  cap_we;
  logic [LINE_IDX_W-1:0] cap_idx;
  logic [127:0]          cap_wdata;

  logic                  accept;
  logic                  enter_resp;
  logic                  eff_we;
  logic [LINE_IDX_W-1:0] eff_idx;
  logic [127:0]          eff_wdata;
  logic [LINE_IDX_W-1:0] req_idx;
  logic                  unused_addr;

  // Contents start at zero and are deliberately kept out of the reset domain.
  logic [127:0] mem [DEPTH] = '{default: '0};

  assign req_idx     = mem_addr[LINE_IDX_W+3:4];
  assign unused_addr = ^{mem_addr[31:LINE_IDX_W+4], mem_addr[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_req) next_state = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (lat_cnt == 4'd1) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With LATENCY=1 the response edge is the acceptance edge, so the
  // transaction fields must bypass the capture registers.
  always_comb begin
    accept     = (state == IDLE) && mem_req;
    enter_resp = (next_state == RESP);
    eff_we     = accept ? mem_we    : cap_we;
    eff_idx    = accept ? req_idx   : cap_idx;
    eff_wdata  = accept ? mem_wdata : cap_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt   <= 4'd0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
    end else begin
      if (accept) begin
        cap_we    <= mem_we;
        cap_idx   <= req_idx;
        cap_wdata <= mem_wdata;
        lat_cnt   <= 4'(LATENCY - 1);
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      mem_ready <= enter_resp;
      if (enter_resp) begin
        if (eff_we) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          mem_rdata <= mem[eff_idx];
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && eff_we) mem[eff_idx] <= eff_wdata;
  end

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: a LATENCY=4 and a LATENCY=1 instance, both checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_main_memory;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hA5A5A5A5_00000000_FFFFFFFF_12345678;
  localparam logic [127:0] D3 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] D4 = 128'h00000000_11111111_22222222_33333333;
  localparam logic [127:0] D5 = 128'hCAFEF00D_0000FFFF_5555AAAA_87654321;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   req;
  logic [1:0]   we;
  logic [31:0]  addr  [2];
  logic [127:0] wdata [2];
  logic [127:0] rdata [2];
  logic [1:0]   rdy;
  logic [15:0]  rdc   [2];
  logic [15:0]  wrc   [2];

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  always #5 clk = ~clk;

  main_memory #(.LINE_IDX_W(10), .LATENCY(LAT0)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[0]), .mem_we(we[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
    .mem_ready(rdy[0]), .rd_count(rdc[0]), .wr_count(wrc[0])
  );

  main_memory #(.LINE_IDX_W(10), .LATENCY(LAT1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[1]), .mem_we(we[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
    .mem_ready(rdy[1]), .rd_count(rdc[1]), .wr_count(wrc[1])
  );

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Model: a request seen while idle at edge e completes at edge e+LAT-1;
  // the cycle after a completion is never idle.
  logic [127:0] model_mem [2][1024];
  bit           pend      [2];
  int           resp_at   [2];
  bit           p_we      [2];
  int           p_idx     [2];
  logic [127:0] p_wdata   [2];
  logic         exp_ready [2];
  logic [127:0] exp_rdata [2];
  logic [15:0]  exp_rdc   [2];
  logic [15:0]  exp_wrc   [2];
  int           edge_no = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 1024; j++) model_mem[i][j] = '0;
      pend[i] = 1'b0;
      exp_ready[i] = 1'b0;
      exp_rdata[i] = '0;
      exp_rdc[i] = 16'd0;
      exp_wrc[i] = 16'd0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          pend[i] = 1'b0;
          exp_ready[i] = 1'b0;
          exp_rdata[i] = '0;
          exp_rdc[i] = 16'd0;
          exp_wrc[i] = 16'd0;
        end
      end else begin
        edge_no++;
        for (int i = 0; i < 2; i++) begin
          int lat;
          bit was_idle;
          lat = (i == 0) ? LAT0 : LAT1;
          was_idle = !pend[i] && !exp_ready[i];
          if (was_idle && req[i]) begin
            pend[i] = 1'b1;
            resp_at[i] = edge_no + lat - 1;
            p_we[i] = we[i];
            p_idx[i] = int'((addr[i] >> 4) & 32'h3FF);
            p_wdata[i] = wdata[i];
          end
          exp_ready[i] = 1'b0;
          if (pend[i] && resp_at[i] == edge_no) begin
            pend[i] = 1'b0;
            exp_ready[i] = 1'b1;
            if (p_we[i]) begin
              model_mem[i][p_idx[i]] = p_wdata[i];
              if (exp_wrc[i] != 16'hFFFF) exp_wrc[i] = exp_wrc[i] + 16'd1;
            end else begin
              exp_rdata[i] = model_mem[i][p_idx[i]];
              if (exp_rdc[i] != 16'hFFFF) exp_rdc[i] = exp_rdc[i] + 16'd1;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int i = 0; i < 2; i++) begin
          check_output($sformatf("ready%0d", i), 128'(rdy[i]), 128'(exp_ready[i]));
          check_output($sformatf("rdata%0d", i), rdata[i], exp_rdata[i]);
          check_output($sformatf("rd_count%0d", i), 128'(rdc[i]), 128'(exp_rdc[i]));
          check_output($sformatf("wr_count%0d", i), 128'(wrc[i]), 128'(exp_wrc[i]));
        end
      end
    end
  end

  task automatic apply_stimulus(input int i, input logic w, input logic [31:0] a,
                                input logic [127:0] d);
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
  endtask

  task automatic wait_ready(input int i, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!rdy[i] && cycles < 40);
    if (!rdy[i]) check_output("ready_timeout", 128'(rdy[i]), 128'(1));
  endtask

  task automatic txn(input int i, input logic w, input logic [31:0] a,
                     input logic [127:0] d, output int cycles);
    @(negedge clk);
    apply_stimulus(i, w, a, d);
    wait_ready(i, cycles);
    req[i] = 1'b0;
  endtask

  initial begin
    int cyc;
    int gap;
    req = 2'b00;
    we  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end
    #1 rst_n = 1'b0;
    checking = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset_ready", 128'(rdy[0]), 128'(0));
    check_output("reset_rdata", rdata[0], 128'(0));
    check_output("reset_rd_count", 128'(rdc[0]), 128'(0));
    rst_n = 1'b1;

    txn(0, 1'b0, 32'h40, '0, cyc);
    check_output("rd40_latency", 128'(cyc), 128'(4));
    check_output("rd40_data", rdata[0], 128'(0));
    check_output("rd40_rd_count", 128'(rdc[0]), 128'(1));

    txn(0, 1'b1, 32'h100, D1, cyc);
    check_output("wr100_wr_count", 128'(wrc[0]), 128'(1));
    txn(0, 1'b0, 32'h10C, '0, cyc);
    check_output("rd10c_data", rdata[0], D1);
    check_output("rd10c_rd_count", 128'(rdc[0]), 128'(2));

    @(negedge clk);
    apply_stimulus(0, 1'b1, 32'h200, D2);
    wait_ready(0, cyc);
    we[0]   = 1'b0;
    addr[0] = 32'h300;
    wait_ready(0, gap);
    req[0] = 1'b0;
    check_output("b2b_gap", 128'(gap), 128'(LAT0 + 1));
    check_output("b2b_rd300_data", rdata[0], 128'(0));

    @(negedge clk);
    apply_stimulus(0, 1'b1, 32'h80, D3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    check_output("abort_wr_count", 128'(wrc[0]), 128'(0));
    repeat (6) @(negedge clk);
    check_output("abort_no_ready", 128'(rdy[0]), 128'(0));
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h80, '0, cyc);
    check_output("abort_rd80_data", rdata[0], 128'(0));
    check_output("abort_wr_count_after", 128'(wrc[0]), 128'(0));

    txn(0, 1'b1, 32'h4000, D4, cyc);
    txn(0, 1'b0, 32'h0, '0, cyc);
    check_output("wrap_rd0_data", rdata[0], D4);

    @(negedge clk);
    apply_stimulus(1, 1'b1, 32'h50, D5);
    @(negedge clk);
    check_output("lat1_ready_next", 128'(rdy[1]), 128'(1));
    req[1] = 1'b0;
    @(negedge clk);
    check_output("lat1_ready_low", 128'(rdy[1]), 128'(0));
    txn(1, 1'b0, 32'h50, '0, cyc);
    check_output("lat1_rd_latency", 128'(cyc), 128'(1));
    check_output("lat1_rd50_data", rdata[1], D5);
    check_output("lat1_counts", 128'({rdc[1], wrc[1]}), 128'({16'd1, 16'd1}));

    @(negedge clk);
    apply_stimulus(1, 1'b0, 32'h100, '0);
    wait_ready(1, cyc);
    addr[1] = 32'h50;
    wait_ready(1, gap);
    req[1] = 1'b0;
    check_output("lat1_b2b_gap", 128'(gap), 128'(LAT1 + 1));
    check_output("lat1_b2b_data", rdata[1], D5);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
